alu_op_sequencer: RTL and testbench

Multi-cycle issue controller that sits in front of the single-cycle ALU and drives its operandA/operandB/aluControl inputs. The ALU shifts by exactly 1 per evaluation, so the sequencer iterates it shamt times to produce full RV32 SLL/SRL/SRA results. All other ops are passed through in one evaluation. Start/busy/done handshake toward the core. The ALU stays an external instance.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_seq_counter.sv | 36 +++
 rtl/alu_op_sequencer.sv | 148 ++++++++++++++
 tb/tb_alu_op_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, the shift-op helper and the sequencer state encoding.
// Used by the ALU, the decoder and the multi-cycle sequencer.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SINGLE = 2'd1,
    ST_SHIFT  = 2'd2
  } seq_state_e;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_seq_counter.sv
// Loadable down-counter for the remaining single-bit shift steps.
// last_o flags the final step; the count parks at zero instead of wrapping.
module alu_seq_counter #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  input  logic             en_i,
  output logic             last_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_value_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last_o = (count_q == WIDTH'(1));

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle issue controller for the one-bit-per-pass ALU; iterates shifts shamt times.
// Optional build macro ALU_SEQ_ABORT_EN adds an abort input that cancels an in-flight op.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
`ifdef ALU_SEQ_ABORT_EN
  input  logic                  abort,
`endif
  input  logic [3:0]            op,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic [DATA_WIDTH-1:0] alu_operand_a,
  output logic [DATA_WIDTH-1:0] alu_operand_b,
  output logic [3:0]            alu_control,
  input  logic [DATA_WIDTH-1:0] alu_result
);

  seq_state_e            state_q, state_d;
  logic [3:0]            op_q, op_d;
  logic [DATA_WIDTH-1:0] opA_q, opA_d;
  logic [DATA_WIDTH-1:0] opB_q, opB_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  done_q, done_d;

  logic                   cntLoad;
  logic                   cntEn;
  logic                   cntLast;
  logic [SHAMT_WIDTH-1:0] shamt;

  assign shamt = op_b[SHAMT_WIDTH-1:0];

  alu_seq_counter #(
    .WIDTH(SHAMT_WIDTH)
  ) u_counter (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (cntLoad),
    .load_value_i(shamt),
    .en_i        (cntEn),
    .last_o      (cntLast)
  );

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    opA_d         = opA_q;
    opB_d         = opB_q;
    acc_d         = acc_q;
    result_d      = result_q;
    done_d        = 1'b0;
    cntLoad       = 1'b0;
    cntEn         = 1'b0;
    alu_operand_a = '0;
    alu_operand_b = '0;
    alu_control   = ALU_ADD;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d  = op;
          opA_d = op_a;
          opB_d = op_b;
          if (is_shift(op) && (shamt != '0)) begin
            acc_d   = op_a;
            cntLoad = 1'b1;
            state_d = ST_SHIFT;
          end else begin
            state_d = ST_SINGLE;
          end
        end
      end

      // A shift that reaches here has a zero amount, so it degenerates to a + 0.
      ST_SINGLE: begin
        alu_operand_a = opA_q;
        if (is_shift(op_q)) begin
          alu_operand_b = '0;
          alu_control   = ALU_ADD;
        end else begin
          alu_operand_b = opB_q;
          alu_control   = op_q;
        end
        result_d = alu_result;
        done_d   = 1'b1;
        state_d  = ST_IDLE;
      end

      ST_SHIFT: begin
        alu_operand_a = acc_q;
        alu_operand_b = '0;
        alu_control   = op_q;
        acc_d         = alu_result;
        cntEn         = 1'b1;
        if (cntLast) begin
          result_d = alu_result;
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

`ifdef ALU_SEQ_ABORT_EN
    if (abort && (state_q != ST_IDLE)) begin
      state_d  = ST_IDLE;
      result_d = result_q;
      done_d   = 1'b0;
      cntEn    = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      opA_q    <= '0;
      opB_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      opA_q    <= opA_d;
      opB_q    <= opB_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q != ST_IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: a one-bit-shift ALU model closes the loop,
// and results/latencies are compared against full-width reference arithmetic.
module tb_alu_op_sequencer;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  op = '0;
  logic [31:0] opA = '0;
  logic [31:0] opB = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [31:0] aluOperandA;
  logic [31:0] aluOperandB;
  logic [3:0]  aluControl;
  logic [31:0] aluResult;
`ifdef ALU_SEQ_ABORT_EN
  logic        abort = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(
    .DATA_WIDTH (32),
    .SHAMT_WIDTH(5)
  ) dut (
    .clk          (clk),
    .rst_n        (rstN),
    .start        (start),
`ifdef ALU_SEQ_ABORT_EN
    .abort        (abort),
`endif
    .op           (op),
    .op_a         (opA),
    .op_b         (opB),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .alu_operand_a(aluOperandA),
    .alu_operand_b(aluOperandB),
    .alu_control  (aluControl),
    .alu_result   (aluResult)
  );

  // The external ALU: one evaluation per cycle, shifts move exactly one bit.
  always_comb begin
    aluResult = '0;
    case (aluControl)
      4'b0000: aluResult = aluOperandA + aluOperandB;
      4'b0001: aluResult = aluOperandA - aluOperandB;
      4'b0010: aluResult = aluOperandA & aluOperandB;
      4'b0011: aluResult = aluOperandA | aluOperandB;
      4'b0100: aluResult = aluOperandA ^ aluOperandB;
      4'b0101: aluResult = aluOperandA << 1;
      4'b0110: aluResult = aluOperandA >> 1;
      4'b0111: aluResult = {aluOperandA[31], aluOperandA[31:1]};
      4'b1000: aluResult = ($signed(aluOperandA) < $signed(aluOperandB)) ? 32'd1 : 32'd0;
      4'b1001: aluResult = (aluOperandA < aluOperandB) ? 32'd1 : 32'd0;
      default: aluResult = '0;
    endcase
  end

  function automatic logic [31:0] refResult(input logic [3:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    int sh;
    sh = int'(b[4:0]);
    case (o)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << sh;
      4'd6: return a >> sh;
      4'd7: return 32'($signed(a) >>> sh);
      4'd8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int refLatency(input logic [3:0] o, input logic [31:0] b);
    if ((o >= 4'd5) && (o <= 4'd7) && (b[4:0] != 5'd0)) return int'(b[4:0]) + 1;
    return 2;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Entered just after a negedge; returns at the negedge where done is seen (or timeout).
  task automatic applyStimulus(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                               input bit holdStart, output int lat, output bit busyAll);
    op = o; opA = a; opB = b; start = 1'b1;
    @(negedge clk);
    start = holdStart;
    op = 4'($urandom); opA = $urandom; opB = $urandom;
    lat = 1;
    busyAll = 1'b1;
    while (!done && lat < 40) begin
      if (!busy) busyAll = 1'b0;
      @(negedge clk);
      lat++;
      if (holdStart) begin
        op = 4'($urandom); opA = $urandom; opB = $urandom;
      end
    end
    start = 1'b0;
  endtask

  task automatic runAndCheck(input string tag, input logic [3:0] o, input logic [31:0] a,
                             input logic [31:0] b, input bit holdStart);
    int  lat;
    bit  busyAll;
    applyStimulus(o, a, b, holdStart, lat, busyAll);
    checkOutput({tag, "_latency"}, 32'(lat), 32'(refLatency(o, b)));
    checkOutput({tag, "_result"}, result, refResult(o, a, b));
    checkOutput({tag, "_doneBusy"}, {30'd0, done, busy}, 32'b10);
    checkOutput({tag, "_busyDuring"}, {31'd0, busyAll}, 32'd1);
  endtask

  initial begin
    logic [31:0] held;
    logic [3:0]  rOp;
    logic [31:0] rA, rB;

    #1;
    checkOutput("reset_state", {29'd0, busy, done, 1'b0}, 32'd0);
    checkOutput("reset_result", result, 32'd0);
    checkOutput("reset_aluA", aluOperandA, 32'd0);
    checkOutput("reset_aluCtl", {28'd0, aluControl}, 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);

    runAndCheck("add", 4'd0, 32'd5, 32'd7, 1'b0);
    @(negedge clk);
    checkOutput("add_donePulse", {31'd0, done}, 32'd0);
    runAndCheck("sll4", 4'd5, 32'h0000_0001, 32'd4, 1'b0);
    @(negedge clk);
    runAndCheck("sra31", 4'd7, 32'h8000_0000, 32'd31, 1'b0);
    @(negedge clk);
    runAndCheck("srl31", 4'd6, 32'h8000_0000, 32'd31, 1'b0);
    @(negedge clk);
    runAndCheck("srlZero", 4'd6, 32'hDEAD_BEEF, 32'h0000_0020, 1'b0);
    @(negedge clk);
    runAndCheck("sllUpperIgnored", 4'd5, 32'h0000_0003, 32'hFFFF_FFE2, 1'b0);
    @(negedge clk);
    runAndCheck("opUnused", 4'd12, 32'h1234_5678, 32'h1111_1111, 1'b0);
    @(negedge clk);

    runAndCheck("holdStart", 4'd5, 32'h0000_00F0, 32'd3, 1'b1);
    @(negedge clk);
    checkOutput("holdStart_notQueued", {30'd0, busy, done}, 32'd0);
    checkOutput("holdStart_resultHolds", result, 32'h0000_0780);
    repeat (3) @(negedge clk);
    checkOutput("idle_resultHolds", result, 32'h0000_0780);

    runAndCheck("b2bFirst", 4'd5, 32'h0000_0001, 32'd2, 1'b0);
    runAndCheck("b2bAdd", 4'd0, 32'd100, 32'd23, 1'b0);
    @(negedge clk);

`ifdef ALU_SEQ_ABORT_EN
    held = result;
    op = 4'd5; opA = 32'd1; opB = 32'd20; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort_idle", {30'd0, busy, done}, 32'd0);
    checkOutput("abort_resultHolds", result, held);
    repeat (20) @(negedge clk);
    checkOutput("abort_noLateDone", {30'd0, busy, done}, 32'd0);
    checkOutput("abort_resultStill", result, held);
    abort = 1'b1;
    runAndCheck("abortIdleStart", 4'd1, 32'd50, 32'd8, 1'b0);
    abort = 1'b0;
    @(negedge clk);
`endif

    held = result;
    checkOutput("preReset_nonzero", {31'd0, held != 32'd0}, 32'd1);
    op = 4'd5; opA = 32'd1; opB = 32'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rstN = 1'b0;
    #1;
    checkOutput("midReset_state", {30'd0, busy, done}, 32'd0);
    checkOutput("midReset_result", result, 32'd0);
    checkOutput("midReset_aluA", aluOperandA, 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    repeat (12) @(negedge clk);
    checkOutput("postReset_noDone", {30'd0, busy, done}, 32'd0);
    checkOutput("postReset_result", result, 32'd0);

    for (int i = 0; i < 40; i++) begin
      rOp = 4'($urandom_range(0, 15));
      rA  = $urandom;
      rB  = $urandom;
      if ($urandom_range(0, 1) == 0) rB[4:0] = 5'($urandom_range(0, 3));
      runAndCheck("random", rOp, rA, rB, 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
